// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch stage ahead of decode.
// Issues sequential word fetches over a req/ack handshake, buffers the returned
// words with their PCs in a DEPTH-entry FIFO and presents the head to decode.
// A redirect flushes the FIFO and restarts fetch at the new (word-aligned) PC.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   redirect, redirect_pc flush and restart request from next-PC logic
//   mem_req, mem_addr     registered fetch request / word address
//   mem_ack, mem_rdata    request completion and returned word
//   ins_valid, ins_ready  head handshake with decode
//   ins, ins_pc, ins_pcp4 head word, its PC and PC+4
module fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins,
    output logic [31:0] ins_pc,
    output logic [31:0] ins_pcp4
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             mem_req_q, mem_req_d;
    logic [31:0]      mem_addr_q, mem_addr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      word_q [DEPTH];
    logic [31:0]      pc_q   [DEPTH];

    logic             deq;
    logic             enq;
    logic [CNT_W-1:0] count_next;
    logic             room;
    logic [31:0]      redirect_pc_al;
    logic [31:0]      fetch_pc_inc;

    // Next-state, request and FIFO bookkeeping
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        redirect_pc_al = {redirect_pc[31:2], 2'b00};
        fetch_pc_inc   = fetch_pc_q + 32'd4;
        deq            = (count_q != '0) && ins_ready;
        enq            = (state_q == S_REQ) && mem_ack && !redirect;
        // occupancy after this edge when no redirect intervenes
        count_next     = count_q + CNT_W'(enq) - CNT_W'(deq);
        room           = count_next < CNT_W'(DEPTH);

        if (redirect) begin
            fetch_pc_d = redirect_pc_al;
            if (state_q == S_IDLE || mem_ack) begin
                // nothing left in flight: issue the new address directly
                state_d    = S_REQ;
                mem_req_d  = 1'b1;
                mem_addr_d = redirect_pc_al;
            end else begin
                // request cannot be withdrawn; hold it and discard its data
                state_d = S_DROP;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (room) begin
                        state_d    = S_REQ;
                        mem_req_d  = 1'b1;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        fetch_pc_d = fetch_pc_inc;
                        mem_addr_d = fetch_pc_inc;
                        if (!room) begin
                            state_d   = S_IDLE;
                            mem_req_d = 1'b0;
                        end
                    end
                end
                S_DROP: begin
                    if (mem_ack) begin
                        state_d    = S_REQ;
                        mem_addr_d = fetch_pc_q;
                    end
                end
                default: begin
                    state_d   = S_IDLE;
                    mem_req_d = 1'b0;
                end
            endcase
        end

        if (redirect) begin
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
        end else begin
            count_d  = count_next;
            rd_ptr_d = rd_ptr_q + PTR_W'(deq);
            wr_ptr_d = wr_ptr_q + PTR_W'(enq);
        end
    end

    // Control registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= RESET_PC;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // FIFO storage; cleared on reset so the head reads as zero
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                word_q[i] <= '0;
                pc_q[i]   <= '0;
            end
        end else if (enq) begin
            word_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]   <= fetch_pc_q;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign ins_valid = (count_q != '0);
    assign ins       = word_q[rd_ptr_q];
    assign ins_pc    = pc_q[rd_ptr_q];
    assign ins_pcp4  = pc_q[rd_ptr_q] + 32'd4;

endmodule

// File: tb/tb_fetch_queue.sv
// Testbench for fetch_queue: directed scenarios plus a randomized phase, all
// checked against a transaction-level model (expected PC queue + memory view).
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        ins_valid;
    logic        ins_ready = 1'b0;
    logic [31:0] ins;
    logic [31:0] ins_pc;
    logic [31:0] ins_pcp4;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins(ins), .ins_pc(ins_pc),
        .ins_pcp4(ins_pcp4)
    );

    int checks = 0;
    int failures = 0;
    int ack_cnt = 0;
    int deq_cnt = 0;
    int wait_cnt = 0;
    int lat_lo = 0;
    int lat_hi = 0;

    // model: PCs that decode should see, in order, and the memory-side view
    logic [31:0] exp_pc_q[$];
    logic [31:0] next_fetch = RESET_PC;
    logic [31:0] req_addr = '0;
    bit          outstanding = 1'b0;
    bit          stale = 1'b0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: check outputs, play memory, drive inputs, advance model
    task automatic cycle(input bit rd, input logic [31:0] rpc, input bit rdy);
        bit ack;
        bit deq;
        chk("ins_valid", 32'(ins_valid), 32'(exp_pc_q.size() != 0));
        if (exp_pc_q.size() != 0) begin
            chk("ins_pc", ins_pc, exp_pc_q[0]);
            chk("ins", ins, word_of(exp_pc_q[0]));
            chk("ins_pcp4", ins_pcp4, exp_pc_q[0] + 32'd4);
        end
        if (mem_req) begin
            if (!outstanding) begin
                chk("req_addr", mem_addr, next_fetch);
                outstanding = 1'b1;
                req_addr    = mem_addr;
                wait_cnt    = $urandom_range(lat_hi, lat_lo);
            end else begin
                chk("req_hold", mem_addr, req_addr);
            end
        end else if (outstanding) begin
            chk("req_withdrawn", 32'(mem_req), 32'd1);
        end

        ack = mem_req && (wait_cnt == 0);
        if (mem_req && wait_cnt != 0) wait_cnt--;
        if (ack) ack_cnt++;
        mem_ack     = ack;
        mem_rdata   = ack ? word_of(mem_addr) : $urandom();
        redirect    = rd;
        redirect_pc = rpc;
        ins_ready   = rdy;

        deq = (exp_pc_q.size() != 0) && rdy;
        if (rd) begin
            exp_pc_q.delete();
            next_fetch = {rpc[31:2], 2'b00};
            if (outstanding) begin
                if (ack) begin
                    outstanding = 1'b0;
                    stale       = 1'b0;
                end else begin
                    stale = 1'b1;
                end
            end
        end else begin
            if (deq) begin
                void'(exp_pc_q.pop_front());
                deq_cnt++;
            end
            if (ack) begin
                outstanding = 1'b0;
                if (stale) begin
                    stale = 1'b0;
                end else begin
                    exp_pc_q.push_back(req_addr);
                    next_fetch = req_addr + 32'd4;
                    chk("no_overfill", 32'(exp_pc_q.size() <= DEPTH), 32'd1);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        redirect  = 1'b0;
        mem_ack   = 1'b0;
        ins_ready = 1'b0;
        @(posedge clk);
        #1;
        exp_pc_q.delete();
        next_fetch  = RESET_PC;
        outstanding = 1'b0;
        stale       = 1'b0;
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, RESET_PC);
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_ins_pc", ins_pc, 32'd0);
        chk("rst_ins_pcp4", ins_pcp4, 32'd4);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input int budget, input bit rdy);
        for (int n = 0; n < budget && !ins_valid; n++) cycle(1'b0, 32'd0, rdy);
        chk("wait_valid", 32'(ins_valid), 32'd1);
    endtask

    task automatic wait_req(input int budget, input bit rdy);
        for (int n = 0; n < budget && !mem_req; n++) cycle(1'b0, 32'd0, rdy);
        chk("wait_req", 32'(mem_req), 32'd1);
    endtask

    initial begin
        // zero-wait memory, decode always ready
        lat_lo = 0; lat_hi = 0;
        do_reset();
        for (int i = 0; i < 10; i++) begin
            chk("zw_valid", 32'(ins_valid), 32'(i >= 2));
            if (i >= 1) begin
                chk("zw_req", 32'(mem_req), 32'd1);
                chk("zw_addr", mem_addr, 32'(4 * (i - 1)));
            end
            if (i >= 2) chk("zw_pc", ins_pc, 32'(4 * (i - 2)));
            cycle(1'b0, 32'd0, 1'b1);
        end

        // fill with decode stalled, then drain and resume
        do_reset();
        ack_cnt = 0;
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b0);
        chk("full_acks", 32'(ack_cnt), 32'd4);
        chk("full_req", 32'(mem_req), 32'd0);
        wait_req(10, 1'b1);
        chk("resume_addr", mem_addr, 32'd16);
        for (int i = 0; i < 8; i++) cycle(1'b0, 32'd0, 1'b1);

        // 3-cycle memory, redirect while request at 8 is outstanding
        lat_lo = 3; lat_hi = 3;
        do_reset();
        for (int n = 0; n < 60 && !(mem_req && mem_addr == 32'd8); n++) cycle(1'b0, 32'd0, 1'b0);
        chk("drop_req_at8", mem_addr, 32'd8);
        cycle(1'b0, 32'd0, 1'b0);
        cycle(1'b1, 32'h0000_0103, 1'b0);
        chk("drop_hold_req", 32'(mem_req), 32'd1);
        chk("drop_hold_addr", mem_addr, 32'd8);
        wait_valid(40, 1'b0);
        chk("drop_first_pc", ins_pc, 32'h0000_0100);
        for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b1);

        // redirect with two entries queued and a same-cycle dequeue
        lat_lo = 0; lat_hi = 0;
        do_reset();
        for (int n = 0; n < 20 && exp_pc_q.size() != 2; n++) cycle(1'b0, 32'd0, 1'b0);
        chk("two_valid", 32'(ins_valid), 32'd1);
        cycle(1'b1, 32'h0000_0040, 1'b1);
        chk("flush_valid", 32'(ins_valid), 32'd0);
        wait_valid(20, 1'b0);
        chk("flush_first_pc", ins_pc, 32'h0000_0040);

        // PC wrap at the top of the address space
        cycle(1'b1, 32'hFFFF_FFFC, 1'b1);
        wait_valid(20, 1'b0);
        chk("wrap_pc0", ins_pc, 32'hFFFF_FFFC);
        chk("wrap_pcp4", ins_pcp4, 32'h0000_0000);
        cycle(1'b0, 32'd0, 1'b1);
        wait_valid(20, 1'b0);
        chk("wrap_pc1", ins_pc, 32'h0000_0000);

        // reset while a request is in flight with three entries queued
        lat_lo = 2; lat_hi = 2;
        do_reset();
        for (int n = 0; n < 60 && !(exp_pc_q.size() == 3 && mem_req); n++) cycle(1'b0, 32'd0, 1'b0);
        chk("mid_req", 32'(mem_req), 32'd1);
        do_reset();
        wait_req(10, 1'b0);
        chk("mid_restart_addr", mem_addr, RESET_PC);

        // randomized traffic
        lat_lo = 0; lat_hi = 3;
        do_reset();
        deq_cnt = 0;
        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 19) == 0, $urandom(), $urandom_range(0, 3) != 0);
        end
        chk("rand_progress", 32'(deq_cnt > 100), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
